// File: rtl/dtmf_pkg.sv
// Shared DTMF definitions: FSM state encoding, keypad code constants,
// row/column tone frequencies and the sample-count helper.
package dtmf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TONE = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [15:0] ROW_697  = 16'd697;
    localparam logic [15:0] ROW_770  = 16'd770;
    localparam logic [15:0] ROW_852  = 16'd852;
    localparam logic [15:0] ROW_941  = 16'd941;
    localparam logic [15:0] COL_1209 = 16'd1209;
    localparam logic [15:0] COL_1336 = 16'd1336;
    localparam logic [15:0] COL_1477 = 16'd1477;
    localparam logic [15:0] COL_1633 = 16'd1633;

    // Codes 0-9 are literal digits; the remaining six map to the extra keys.
    localparam logic [3:0] DIG_STAR = 4'hA;
    localparam logic [3:0] DIG_HASH = 4'hB;
    localparam logic [3:0] DIG_A    = 4'hC;
    localparam logic [3:0] DIG_B    = 4'hD;
    localparam logic [3:0] DIG_C    = 4'hE;
    localparam logic [3:0] DIG_D    = 4'hF;

    function automatic int samples(input int rate, input int ms);
        return rate * ms / 1000;
    endfunction

    function automatic logic [15:0] row_freq(input logic [3:0] code);
        case (code)
            4'd1, 4'd2, 4'd3, DIG_A: return ROW_697;
            4'd4, 4'd5, 4'd6, DIG_B: return ROW_770;
            4'd7, 4'd8, 4'd9, DIG_C: return ROW_852;
            default:                 return ROW_941;
        endcase
    endfunction

    function automatic logic [15:0] col_freq(input logic [3:0] code);
        case (code)
            4'd1, 4'd4, 4'd7, DIG_STAR: return COL_1209;
            4'd2, 4'd5, 4'd8, 4'd0:     return COL_1336;
            4'd3, 4'd6, 4'd9, DIG_HASH: return COL_1477;
            default:                    return COL_1633;
        endcase
    endfunction

endpackage

// File: rtl/dtmf_digit_fifo.sv
// Keypad-code buffer: 4-bit wide, power-of-two depth, occupancy counter
// drives full/empty; flush clears it in one clock.
module dtmf_digit_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       push,
    input  logic       pop,
    input  logic [3:0] wr_data,
    output logic [3:0] rd_data,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + (AW+1)'(1);
            else if (do_pop && !do_push) count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/dtmf_sequencer.sv
// DTMF digit player: buffers keypad codes and drives the row/column NCO
// frequency words for a tone period then a silent gap. Optional DTMF_MIX_EN adds a tone mixer.
module dtmf_sequencer
    import dtmf_pkg::*;
#(
    parameter int SAMPLING_RATE = 8000,
    parameter int TONE_MS       = 50,
    parameter int GAP_MS        = 50,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef DTMF_MIX_EN
    input  logic signed [15:0] sin_row,
    input  logic signed [15:0] sin_col,
    output logic signed [15:0] mix_out,
`endif
    input  logic              sample_en,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [3:0]        in_digit,
    output logic              in_ready,
    output logic [15:0]       freq_row,
    output logic [15:0]       freq_col,
    output logic              tone_active,
    output logic              busy,
    output logic              digit_done
);
    localparam int TONE_SAMPLES = samples(SAMPLING_RATE, TONE_MS);
    localparam int GAP_SAMPLES  = samples(SAMPLING_RATE, GAP_MS);
    localparam int MAX_SAMPLES  = (TONE_SAMPLES > GAP_SAMPLES) ? TONE_SAMPLES : GAP_SAMPLES;
    localparam int CNT_W        = (MAX_SAMPLES > 1) ? $clog2(MAX_SAMPLES) : 1;
    localparam logic [CNT_W-1:0] TONE_LAST = CNT_W'(TONE_SAMPLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_SAMPLES - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [3:0]        fifo_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;

    // A push coinciding with flush is dropped even though in_ready is high.
    assign push     = in_valid && !fifo_full && !flush;
    assign pop      = (state == ST_IDLE) && !fifo_empty && !flush;
    assign in_ready = !fifo_full;
    assign busy     = (state != ST_IDLE) || !fifo_empty;

    dtmf_digit_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .push    (push),
        .pop     (pop),
        .wr_data (in_digit),
        .rd_data (fifo_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            freq_row    <= '0;
            freq_col    <= '0;
            tone_active <= 1'b0;
            digit_done  <= 1'b0;
        end else begin
            digit_done <= 1'b0;
            if (flush) begin
                state       <= ST_IDLE;
                cnt         <= '0;
                freq_row    <= '0;
                freq_col    <= '0;
                tone_active <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (!fifo_empty) begin
                            freq_row    <= row_freq(fifo_data);
                            freq_col    <= col_freq(fifo_data);
                            tone_active <= 1'b1;
                            cnt         <= '0;
                            state       <= ST_TONE;
                        end
                    end
                    ST_TONE: begin
                        if (sample_en) begin
                            if (cnt == TONE_LAST) begin
                                freq_row    <= '0;
                                freq_col    <= '0;
                                tone_active <= 1'b0;
                                cnt         <= '0;
                                state       <= ST_GAP;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                    end
                    ST_GAP: begin
                        if (sample_en) begin
                            if (cnt == GAP_LAST) begin
                                digit_done <= 1'b1;
                                cnt        <= '0;
                                state      <= ST_IDLE;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef DTMF_MIX_EN
    logic signed [15:0] mix_q;

    // Halving each input first keeps the sum inside 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            mix_q <= '0;
        else if (!tone_active) mix_q <= '0;
        else if (sample_en)    mix_q <= (sin_row >>> 1) + (sin_col >>> 1);
    end

    assign mix_out = tone_active ? mix_q : '0;
`endif

endmodule

// File: tb/tb_dtmf_sequencer.sv
// Self-checking bench for dtmf_sequencer: queue-based reference model, keypad-grid
// frequency tables, table-driven digit vectors, corner sequences and random traffic.
module tb_dtmf_sequencer;
    localparam int TS    = 4;
    localparam int GS    = 2;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_en;
    logic        flush;
    logic        in_valid;
    logic [3:0]  in_digit;
    logic        in_ready;
    logic [15:0] freq_row;
    logic [15:0] freq_col;
    logic        tone_active;
    logic        busy;
    logic        digit_done;
`ifdef DTMF_MIX_EN
    logic signed [15:0] sin_row;
    logic signed [15:0] sin_col;
    logic signed [15:0] mix_out;
`endif

    dtmf_sequencer #(
        .SAMPLING_RATE (1000),
        .TONE_MS       (TS),
        .GAP_MS        (GS),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef DTMF_MIX_EN
        .sin_row     (sin_row),
        .sin_col     (sin_col),
        .mix_out     (mix_out),
`endif
        .sample_en   (sample_en),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_digit    (in_digit),
        .in_ready    (in_ready),
        .freq_row    (freq_row),
        .freq_col    (freq_col),
        .tone_active (tone_active),
        .busy        (busy),
        .digit_done  (digit_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int rtab [16];
    int ctab [16];

    // Reference model: pending digits, digit being played, strobes since it started.
    int q_m[$];
    bit play_m;
    int cur_m;
    int str_m;
    bit done_m;
    int mix_m;
    bit rand_sin = 1'b1;

    bit prev_tone;
    int done_cnt;
    int seen_row[$];
    int seen_col[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    function automatic void build_tables();
        string keys [4];
        int    rf [4];
        int    cf [4];
        int    code;
        byte   ch;
        keys = '{"123A", "456B", "789C", "*0#D"};
        rf   = '{697, 770, 852, 941};
        cf   = '{1209, 1336, 1477, 1633};
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                ch = keys[r][c];
                if (ch >= "0" && ch <= "9") code = int'(ch) - int'("0");
                else if (ch == "*")         code = 10;
                else if (ch == "#")         code = 11;
                else                        code = 12 + int'(ch) - int'("A");
                rtab[code] = rf[r];
                ctab[code] = cf[c];
            end
        end
    endfunction

    function automatic void model_reset();
        q_m.delete();
        play_m = 1'b0;
        cur_m  = 0;
        str_m  = 0;
        done_m = 1'b0;
        mix_m  = 0;
    endfunction

    function automatic void model_step();
        int had;
        bit take;
        logic signed [15:0] s;
        had  = q_m.size();
        take = in_valid && (had < DEPTH);
        if (!rst_n) begin
            model_reset();
            return;
        end
        done_m = 1'b0;
        if (flush) begin
            q_m.delete();
            play_m = 1'b0;
            mix_m  = 0;
            return;
        end
`ifdef DTMF_MIX_EN
        s = (sin_row >>> 1) + (sin_col >>> 1);
        if (play_m && str_m < TS && sample_en) mix_m = int'(s);
`else
        s = '0;
`endif
        if (!play_m) begin
            if (had > 0) begin
                cur_m  = q_m.pop_front();
                play_m = 1'b1;
                str_m  = 0;
                mix_m  = 0;
            end
        end else if (sample_en) begin
            str_m++;
            if (str_m == TS + GS) begin
                play_m = 1'b0;
                done_m = 1'b1;
            end
        end
        if (take) q_m.push_back(int'(in_digit));
    endfunction

    function automatic bit tone_m();
        return play_m && (str_m < TS);
    endfunction

    task automatic compare_all();
        chk("in_ready",    int'(in_ready),    int'(q_m.size() < DEPTH));
        chk("busy",        int'(busy),        int'(play_m || q_m.size() > 0));
        chk("tone_active", int'(tone_active), int'(tone_m()));
        chk("freq_row",    int'(freq_row),    tone_m() ? rtab[cur_m] : 0);
        chk("freq_col",    int'(freq_col),    tone_m() ? ctab[cur_m] : 0);
        chk("digit_done",  int'(digit_done),  int'(done_m));
`ifdef DTMF_MIX_EN
        chk("mix_out",     int'(mix_out),     tone_m() ? mix_m : 0);
`endif
    endtask

    task automatic tick();
        sample_en = (cyc % 3 == 0);
`ifdef DTMF_MIX_EN
        if (rand_sin) begin
            sin_row = 16'($urandom);
            sin_col = 16'($urandom);
        end
`endif
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        if (tone_active && !prev_tone) begin
            seen_row.push_back(int'(freq_row));
            seen_col.push_back(int'(freq_col));
        end
        prev_tone = tone_active;
        if (digit_done) done_cnt++;
        compare_all();
    endtask

    task automatic push(input logic [3:0] d);
        in_valid = 1'b1;
        in_digit = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        chk({name, "_idle_timeout"}, int'(busy), 0);
    endtask

    typedef struct {
        logic [3:0] digit;
        int         row;
        int         col;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int n;
        int stall;
        build_tables();
        model_reset();
        rst_n = 1'b0; sample_en = 1'b0; flush = 1'b0; in_valid = 1'b0; in_digit = '0;
`ifdef DTMF_MIX_EN
        sin_row = '0; sin_col = '0;
`endif
        prev_tone = 1'b0;
        done_cnt  = 0;

        // 1: reset values, then single digit '5' with latency check
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_freq_row", int'(freq_row), 0);
        push(4'h5);
        chk("lat_tone_early", int'(tone_active), 0);
        chk("lat_busy", int'(busy), 1);
        tick();
        chk("lat5_row", int'(freq_row), 770);
        chk("lat5_col", int'(freq_col), 1336);
        done_cnt = 0;
        wait_idle("t1", 100);
        chk("t1_done_cnt", done_cnt, 1);

        // 2: table-driven back-to-back digits
        vecs[0] = '{4'hA, 941, 1209};
        vecs[1] = '{4'h0, 941, 1336};
        vecs[2] = '{4'hB, 941, 1477};
        vecs[3] = '{4'h5, 770, 1336};
        vecs[4] = '{4'hF, 941, 1633};
        vecs[5] = '{4'hC, 697, 1633};
        seen_row.delete(); seen_col.delete(); done_cnt = 0;
        for (int i = 0; i < 6; i++) push(vecs[i].digit);
        wait_idle("t2", 400);
        chk("t2_tone_count", seen_row.size(), 6);
        chk("t2_done_count", done_cnt, 6);
        for (int i = 0; i < 6 && i < seen_row.size(); i++) begin
            chk($sformatf("t2_row%0d", i), seen_row[i], vecs[i].row);
            chk($sformatf("t2_col%0d", i), seen_col[i], vecs[i].col);
        end

        // 3: fill the FIFO while the first digit plays, then stall the 10th
        for (int i = 0; i < 9; i++) push(4'(i + 1));
        chk("t3_full_ready", int'(in_ready), 0);
        in_valid = 1'b1; in_digit = 4'h0; stall = 0;
        while (!in_ready && stall < 200) begin
            tick();
            stall++;
        end
        chk("t3_stalled", int'(stall > 0), 1);
        chk("t3_stall_bound", int'(stall < 200), 1);
        tick();
        in_valid = 1'b0;
        wait_idle("t3", 2000);

        // 4: flush mid-tone with queued digits; coincident push is dropped
        for (int i = 0; i < 4; i++) push(4'(i + 6));
        tick(); tick();
        chk("t4_pre_tone", int'(tone_active), 1);
        flush = 1'b1; in_valid = 1'b1; in_digit = 4'h3;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("t4_freq_row", int'(freq_row), 0);
        chk("t4_busy", int'(busy), 0);
        done_cnt = 0;
        repeat (30) tick();
        chk("t4_no_done", done_cnt, 0);

        // 5: asynchronous reset in the gap
        push(4'h8);
        n = 0;
        while (!(play_m && str_m >= TS) && n < 100) begin
            tick();
            n++;
        end
        chk("t5_reached_gap", int'(play_m && str_m >= TS), 1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        prev_tone = 1'b0;
        chk("t5_rst_busy", int'(busy), 0);
        chk("t5_rst_ready", int'(in_ready), 1);
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
        push(4'h2);
        tick();
        chk("t5_restart_row", int'(freq_row), 697);
        chk("t5_restart_col", int'(freq_col), 1336);
        wait_idle("t5", 100);

`ifdef DTMF_MIX_EN
        // 6: mixer with fixed NCO samples
        rand_sin = 1'b0;
        sin_row = 16'sh4000; sin_col = 16'sh4000;
        push(4'h1);
        n = 0;
        while (!(tone_active && mix_out != 0) && n < 20) begin
            tick();
            n++;
        end
        chk("t6_mix_tone", int'(mix_out), 16'h4000);
        while (tone_active && n < 60) begin
            tick();
            n++;
        end
        chk("t6_mix_gap", int'(mix_out), 0);
        wait_idle("t6", 100);
        rand_sin = 1'b1;
`endif

        // random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            in_valid = ($urandom % 3 == 0);
            in_digit = 4'($urandom);
            flush    = ($urandom % 60 == 0);
            tick();
        end
        in_valid = 1'b0; flush = 1'b0;
        wait_idle("rand", 3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
